// File: rtl/clk_div_pkg.sv
// Shared types and constants for the glitch-free programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/glitch_free_clk_div_if.sv
// Control/status bundle of the clock divider; master drives requests, slave is the divider.
// Ratio handshake: a transfer happens on a clk edge where div_valid && div_ready are both high;
// div_valid/div_value must stay stable until that edge, and div_ready never depends on div_valid.
interface glitch_free_clk_div_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             div_valid;
  logic [CNT_W-1:0] div_value;
  logic             div_ready;
  logic             clk_out;
  logic             clk_active;
  logic             busy;
  logic             err_div;

  modport master (
    output en, div_valid, div_value,
    input  div_ready, clk_out, clk_active, busy, err_div
  );

  modport slave (
    input  en, div_valid, div_value,
    output div_ready, clk_out, clk_active, busy, err_div
  );
endinterface

// File: rtl/clk_div_phase_cnt.sv
// Phase counter of one output period: flags the wrap edge and registers clk_out.
module clk_div_phase_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_active,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_boundary,
  output logic             o_clk
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_high;

  assign w_high     = i_div - (i_div >> 1);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign o_boundary = i_active && (r_cnt == i_div - CNT_W'(1));

  // A new period always opens with a high phase, whatever ratio it uses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      o_clk <= 1'b0;
    end else if (!i_run) begin
      r_cnt <= '0;
      o_clk <= 1'b0;
    end else if (!i_active || o_boundary) begin
      r_cnt <= '0;
      o_clk <= 1'b1;
    end else begin
      r_cnt <= w_cnt_inc;
      o_clk <= (w_cnt_inc < w_high);
    end
  end

endmodule

// File: rtl/glitch_free_clk_div.sv
// Runtime-programmable glitch-free clock divider: run/stop FSM plus ratio handshake,
// with ratio changes and stops deferred to output-period boundaries.
module glitch_free_clk_div
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  glitch_free_clk_div_if.slave  bus,
  output state_t                o_dbg_state
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend;
  logic             r_busy;
  logic             r_err;
  logic             r_active;
  logic             w_boundary;
  logic             w_clk_out;
  logic             w_xfer;
  logic             w_bad;
  logic             w_good;

  assign w_xfer = bus.div_valid && !r_busy;
  assign w_bad  = w_xfer && (bus.div_value < CNT_W'(MIN_DIV));
  assign w_good = w_xfer && !w_bad;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (bus.en) w_next_state = RUN;
      RUN:      if (!bus.en) w_next_state = w_boundary ? IDLE : STOPPING;
      STOPPING: begin
        if (bus.en)          w_next_state = RUN;
        else if (w_boundary) w_next_state = IDLE;
      end
      default:  w_next_state = IDLE;
    endcase
  end

  clk_div_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_active   (r_state != IDLE),
    .i_run      (w_next_state != IDLE),
    .i_div      (r_div),
    .o_boundary (w_boundary),
    .o_clk      (w_clk_out)
  );

  // A ratio accepted on a boundary edge governs the period opening at that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_div    <= CNT_W'(DEFAULT_DIV);
      r_pend   <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_active <= (w_next_state != IDLE);
      r_err    <= w_bad;
      if (r_busy && (w_boundary || r_state == IDLE)) begin
        r_div  <= r_pend;
        r_busy <= 1'b0;
      end
      if (w_good) begin
        if (w_boundary) begin
          r_div <= bus.div_value;
        end else begin
          r_pend <= bus.div_value;
          r_busy <= 1'b1;
        end
      end
    end
  end

  assign bus.clk_out    = w_clk_out;
  assign bus.clk_active = r_active;
  assign bus.busy       = r_busy;
  assign bus.div_ready  = !r_busy;
  assign bus.err_div    = r_err;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_glitch_free_clk_div.sv
// Directed bench for glitch_free_clk_div: hand-computed clk_out waveforms and status flags.
module tb_glitch_free_clk_div;
  import clk_div_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     n_checks;
  int     n_errors;

  glitch_free_clk_div_if #(.CNT_W(8)) bus ();

  glitch_free_clk_div #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pat is read MSB first: bit n-1 is the value expected after the first edge.
  task automatic wave(input string tag, input logic [31:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, {31'd0, bus.clk_out}, {31'd0, pat[n-1-i]});
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.div_valid = 1'b0;
    bus.div_value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk_out", {31'd0, bus.clk_out}, 32'd0);
    chk("rst_active",  {31'd0, bus.clk_active}, 32'd0);
    chk("rst_ready",   {31'd0, bus.div_ready}, 32'd1);
    chk("rst_busy",    {31'd0, bus.busy}, 32'd0);
    chk("rst_err",     {31'd0, bus.err_div}, 32'd0);
    chk("rst_state",   32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    tick();
    chk("idle_low", {31'd0, bus.clk_out}, 32'd0);

    // default ratio 4 from the first edge
    bus.en = 1'b1;
    wave("start_d4", 32'b11001100, 8);
    chk("d4_ready",  {31'd0, bus.div_ready}, 32'd1);
    chk("d4_state",  32'(dbg_state), 32'(RUN));
    chk("d4_active", {31'd0, bus.clk_active}, 32'd1);

    // D=5 offered in the high phase, applied at the next boundary
    wave("d4_pos0", 32'b1, 1);
    bus.div_valid = 1'b1;
    bus.div_value = 8'd5;
    tick();
    bus.div_valid = 1'b0;
    chk("d5_xfer_clk",   {31'd0, bus.clk_out}, 32'd1);
    chk("d5_xfer_busy",  {31'd0, bus.busy}, 32'd1);
    chk("d5_xfer_ready", {31'd0, bus.div_ready}, 32'd0);
    wave("d4_tail", 32'b00, 2);
    chk("d5_busy_hold", {31'd0, bus.busy}, 32'd1);
    wave("d5_first", 32'b1, 1);
    chk("d5_busy_clr",  {31'd0, bus.busy}, 32'd0);
    chk("d5_ready_set", {31'd0, bus.div_ready}, 32'd1);
    wave("d5", 32'b110011100, 9);

    // D=1 rejected on a boundary edge
    bus.div_valid = 1'b1;
    bus.div_value = 8'd1;
    tick();
    bus.div_valid = 1'b0;
    chk("bad_clk",  {31'd0, bus.clk_out}, 32'd1);
    chk("bad_err",  {31'd0, bus.err_div}, 32'd1);
    chk("bad_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("bad_err_clr", {31'd0, bus.err_div}, 32'd0);
    chk("bad_clk2",    {31'd0, bus.clk_out}, 32'd1);
    wave("d5_after_err", 32'b10011100, 8);

    // D=6 on a boundary, then stop from the high phase
    bus.div_valid = 1'b1;
    bus.div_value = 8'd6;
    tick();
    bus.div_valid = 1'b0;
    chk("d6_bypass_clk",  {31'd0, bus.clk_out}, 32'd1);
    chk("d6_bypass_busy", {31'd0, bus.busy}, 32'd0);
    wave("d6_pos1", 32'b1, 1);
    bus.en = 1'b0;
    tick();
    chk("stop_clk",    {31'd0, bus.clk_out}, 32'd1);
    chk("stop_state",  32'(dbg_state), 32'(STOPPING));
    chk("stop_active", {31'd0, bus.clk_active}, 32'd1);
    wave("d6_stop_tail", 32'b000, 3);
    chk("stop_active2", {31'd0, bus.clk_active}, 32'd1);
    tick();
    chk("stopped_clk",    {31'd0, bus.clk_out}, 32'd0);
    chk("stopped_active", {31'd0, bus.clk_active}, 32'd0);
    chk("stopped_state",  32'(dbg_state), 32'(IDLE));
    wave("stopped_low", 32'b000, 3);

    // restart, drop en, re-raise it before the boundary
    bus.en = 1'b1;
    wave("restart", 32'b11, 2);
    bus.en = 1'b0;
    tick();
    chk("resume_stop_state", 32'(dbg_state), 32'(STOPPING));
    bus.en = 1'b1;
    tick();
    chk("resume_clk",   {31'd0, bus.clk_out}, 32'd0);
    chk("resume_state", 32'(dbg_state), 32'(RUN));
    wave("resume", 32'b00111000, 8);

    // D=2 on an exact boundary, then stop directly on a boundary
    bus.div_valid = 1'b1;
    bus.div_value = 8'd2;
    tick();
    bus.div_valid = 1'b0;
    chk("d2_first_clk", {31'd0, bus.clk_out}, 32'd1);
    chk("d2_busy",      {31'd0, bus.busy}, 32'd0);
    wave("d2", 32'b01010, 5);
    bus.en = 1'b0;
    tick();
    chk("direct_idle_clk",    {31'd0, bus.clk_out}, 32'd0);
    chk("direct_idle_active", {31'd0, bus.clk_active}, 32'd0);
    chk("direct_idle_state",  32'(dbg_state), 32'(IDLE));

    // D=3 loaded while idle
    bus.div_valid = 1'b1;
    bus.div_value = 8'd3;
    tick();
    bus.div_valid = 1'b0;
    chk("idle_xfer_busy",  {31'd0, bus.busy}, 32'd1);
    chk("idle_xfer_ready", {31'd0, bus.div_ready}, 32'd0);
    chk("idle_xfer_clk",   {31'd0, bus.clk_out}, 32'd0);
    tick();
    chk("idle_apply_busy",  {31'd0, bus.busy}, 32'd0);
    chk("idle_apply_ready", {31'd0, bus.div_ready}, 32'd1);
    bus.en = 1'b1;
    wave("d3", 32'b110110110, 9);

    // D=8, pending D=5, then asynchronous reset mid-period
    bus.div_valid = 1'b1;
    bus.div_value = 8'd8;
    tick();
    bus.div_valid = 1'b0;
    chk("d8_first_clk", {31'd0, bus.clk_out}, 32'd1);
    wave("d8", 32'b111000011, 9);
    bus.div_valid = 1'b1;
    bus.div_value = 8'd5;
    tick();
    bus.div_valid = 1'b0;
    chk("d8_pend_busy", {31'd0, bus.busy}, 32'd1);
    chk("d8_pend_clk",  {31'd0, bus.clk_out}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_clk",    {31'd0, bus.clk_out}, 32'd0);
    chk("arst_active", {31'd0, bus.clk_active}, 32'd0);
    chk("arst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("arst_ready",  {31'd0, bus.div_ready}, 32'd1);
    chk("arst_state",  32'(dbg_state), 32'(IDLE));
    tick();
    rst = 1'b0;
    chk("arst_hold_clk", {31'd0, bus.clk_out}, 32'd0);
    wave("post_rst_d4", 32'b11001100, 8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
